// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the 3-sample majority vote.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int OS_RATE   = 16;
  localparam int DATA_BITS = 8;
  localparam int OS_W      = $clog2(OS_RATE);
  localparam int BIT_W     = $clog2(DATA_BITS);

  typedef logic [OS_W-1:0]  os_cnt_t;
  typedef logic [BIT_W-1:0] bit_idx_t;

  localparam os_cnt_t  SAMPLE_LO  = os_cnt_t'(7);
  localparam os_cnt_t  SAMPLE_MID = os_cnt_t'(8);
  localparam os_cnt_t  SAMPLE_HI  = os_cnt_t'(9);
  localparam os_cnt_t  OS_LAST    = os_cnt_t'(OS_RATE - 1);
  localparam bit_idx_t BIT_LAST   = bit_idx_t'(DATA_BITS - 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered occupancy.
// A push while full is accepted only if a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // While empty the output holds the most recent head instead of stale storage.
  assign rdata = empty ? last_q : mem[rd_ptr];

  // NOTE: the storage array is deliberately left without reset; no entry is
  // observable until it has been written, so resetting it would only add flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (!empty)  last_q <= mem[rd_ptr];
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver: RX synchroniser, 16x oversampling with majority vote,
// deframer FSM and a FWFT receive FIFO behind a valid/ready interface.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV     = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          Clk_14_7456MHz,
  input  logic                          sys_rst_n,
  input  logic                          RX,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int               DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [DIV_W-1:0]       div_q;
  logic                   tick;

  rx_state_t              state_q, state_d;
  os_cnt_t                os_q, os_d;
  bit_idx_t               bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   s7_q, s7_d;
  logic                   s8_q, s8_d;
  logic                   armed_q, armed_d;
  logic                   bit_maj;
  logic                   push_byte;
  logic                   frame_err_d;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;

  // Synchroniser presets to the idle (high) line level.
  always_ff @(posedge Clk_14_7456MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) sync_q <= '1;
    else            sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge Clk_14_7456MHz or negedge sys_rst_n) begin
    if (!sys_rst_n)          div_q <= '0;
    else if (div_q == DIV_LAST) div_q <= '0;
    else                     div_q <= div_q + 1'b1;
  end

  assign tick = (div_q == DIV_LAST);

  // The third vote is taken live at SAMPLE_HI, so the decision is not delayed.
  assign bit_maj = maj3(s7_q, s8_q, rx_s);

  // NOTE: combinational logic uses blocking assignments with every output
  // given a default first, so no path can leave a value unassigned (latch).
  always_comb begin
    state_d     = state_q;
    os_d        = os_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    s7_d        = s7_q;
    s8_d        = s8_q;
    armed_d     = armed_q;
    push_byte   = 1'b0;
    frame_err_d = 1'b0;

    if (tick) begin
      if (state_q != IDLE) begin
        os_d = os_q + 1'b1;
        if (os_q == SAMPLE_LO)  s7_d = rx_s;
        if (os_q == SAMPLE_MID) s8_d = rx_s;
      end

      case (state_q)
        IDLE: begin
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = START;
            os_d    = '0;
            armed_d = 1'b0;
          end
        end
        START: begin
          if (os_q == SAMPLE_HI && bit_maj) begin
            state_d = IDLE;
          end else if (os_q == OS_LAST) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
        DATA: begin
          if (os_q == SAMPLE_HI) begin
            shift_d[bit_q] = bit_maj;
          end else if (os_q == OS_LAST) begin
            bit_d = bit_q + 1'b1;
            if (bit_q == BIT_LAST) state_d = STOP;
          end
        end
        STOP: begin
          // Leaving half a bit early leaves margin for a fast transmitter.
          if (os_q == SAMPLE_HI) begin
            state_d = IDLE;
            if (bit_maj) push_byte   = 1'b1;
            else         frame_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk_14_7456MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      os_q      <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      s7_q      <= 1'b1;
      s8_q      <= 1'b1;
      armed_q   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_q      <= os_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      s7_q      <= s7_d;
      s8_q      <= s8_d;
      armed_q   <= armed_d;
      frame_err <= frame_err_d;
      overrun   <= push_byte & fifo_full & ~fifo_pop;
    end
  end

  // The completed byte is the shift register with the final bit already in.
  assign fifo_pop = rx_ready & rx_valid;
  assign rx_valid = ~fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clk_14_7456MHz),
    .rst_n (sys_rst_n),
    .push  (push_byte),
    .wdata (shift_q),
    .pop   (fifo_pop),
    .rdata (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (rx_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: serial frames are driven at 115200
// baud and a byte scoreboard is compared against every pop from the FIFO.
module tb_uart_rx_fifo;

  localparam int CLK_DIV     = 8;
  localparam int FIFO_DEPTH  = 16;
  localparam int SYNC_STAGES = 2;
  localparam int BIT_CLKS    = 16 * CLK_DIV;
  localparam int CW          = $clog2(FIFO_DEPTH) + 1;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          rx       = 1'b1;
  logic          rx_ready = 1'b0;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [CW-1:0] rx_count;
  logic          frame_err;
  logic          overrun;

  int         n_vec = 0;
  int         n_err = 0;
  int         edge_n;
  logic [7:0] exp_q [$];
  int         fe_cnt = 0, ov_cnt = 0;
  int         exp_fe = 0, exp_ov = 0;
  int         rise_edge = -1;
  logic       prev_valid = 1'b0;
  logic [7:0] last_pop = 8'h00;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_DIV     (CLK_DIV),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .Clk_14_7456MHz (clk),
    .sys_rst_n      (rst_n),
    .RX             (rx),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .rx_count       (rx_count),
    .frame_err      (frame_err),
    .overrun        (overrun)
  );

  // Clock edges since reset release; oversample ticks act on multiples of CLK_DIV.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Output monitor: scoreboard pops, pulse counting, rx_valid rise edge.
  always @(negedge clk) begin
    prev_valid <= rx_valid;
    if (rst_n) begin
      if (rx_valid && rx_ready) begin
        last_pop <= rx_data;
        if (exp_q.size() == 0) check("pop_unexpected", {31'd0, rx_valid}, 32'd0);
        else                   check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (overrun)   ov_cnt <= ov_cnt + 1;
      if (frame_err || overrun) check("fe_ov_excl", {31'd0, frame_err & overrun}, 32'd0);
      if (rx_valid && !prev_valid) rise_edge <= edge_n;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Edge at which the STOP-bit decision for a start bit driven after edge e is
  // registered: rx_s is low after edge e+2, the next tick edge enters START,
  // and the stop sample at os 9 falls 16 + 8*16 + 10 ticks later.
  function automatic int stop_edge(input int e);
    return ((e + SYNC_STAGES) / CLK_DIV + 1) * CLK_DIV + (16 + 8 * 16 + 10) * CLK_DIV;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop, input bit keep);
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(BIT_CLKS);
    end
    rx = stop;
    wait_clks(BIT_CLKS);
    if (keep) begin
      if (!stop)                          exp_fe++;
      else if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(d);
      else                                exp_ov++;
    end
  endtask

  task automatic send_ok(input logic [7:0] d);
    send_frame(d, 1'b1, 1'b1);
    wait_clks(32);
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    for (int i = 0; i < 2 * FIFO_DEPTH + 4; i++) begin
      @(negedge clk);
      if (!rx_valid) break;
    end
    rx_ready = 1'b0;
    wait_clks(1);
    check("drain_valid", {31'd0, rx_valid}, 32'd0);
    check("drain_count", {{(32-CW){1'b0}}, rx_count}, 32'd0);
    check("drain_left", exp_q.size(), 32'd0);
  endtask

  initial begin
    int e;
    int s;

    // Reset values
    wait_clks(4);
    check("reset_outputs", {16'd0, rx_valid, rx_count, rx_data, frame_err, overrun}, 32'd0);
    rst_n = 1'b1;
    wait_clks(64);

    // Basic byte with exact push latency, then a single-cycle pop
    e = edge_n;
    s = stop_edge(e);
    send_ok(8'h55);
    check("basic_latency", rise_edge, s);
    check("basic_valid", {31'd0, rx_valid}, 32'd1);
    check("basic_count", {{(32-CW){1'b0}}, rx_count}, exp_q.size());
    check("basic_head", {24'd0, rx_data}, 32'h55);
    rx_ready = 1'b1;
    wait_clks(1);
    rx_ready = 1'b0;
    wait_clks(1);
    check("basic_pop_valid", {31'd0, rx_valid}, 32'd0);
    check("basic_pop_count", {{(32-CW){1'b0}}, rx_count}, 32'd0);

    // Glitch rejection
    rx = 1'b0;
    wait_clks(32);
    rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check("glitch_count", {{(32-CW){1'b0}}, rx_count}, exp_q.size());
    check("glitch_fe", fe_cnt, exp_fe);
    send_ok(8'hA3);
    check("after_glitch_count", {{(32-CW){1'b0}}, rx_count}, exp_q.size());
    drain();

    // Framing error followed by a break, then a good byte
    send_frame(8'h3C, 1'b0, 1'b1);
    wait_clks(2 * BIT_CLKS);
    rx = 1'b1;
    wait_clks(BIT_CLKS);
    check("ferr_pulses", fe_cnt, exp_fe);
    check("ferr_count", {{(32-CW){1'b0}}, rx_count}, exp_q.size());
    send_ok(8'h81);
    check("after_ferr_count", {{(32-CW){1'b0}}, rx_count}, exp_q.size());
    drain();

    // Overrun on the 17th byte
    for (int i = 0; i <= FIFO_DEPTH; i++) send_ok(8'(i));
    check("ovr_count", {{(32-CW){1'b0}}, rx_count}, exp_q.size());
    check("ovr_pulses", ov_cnt, exp_ov);
    check("ovr_fe", fe_cnt, exp_fe);
    drain();

    // Full FIFO with a pop in exactly the push cycle
    for (int i = 0; i < FIFO_DEPTH; i++) send_ok(8'(8'h20 + i));
    check("full_count", {{(32-CW){1'b0}}, rx_count}, exp_q.size());
    e = edge_n;
    s = stop_edge(e);
    fork
      send_frame(8'h7E, 1'b1, 1'b1);
      begin
        for (int k = 0; k < 4 * BIT_CLKS * 10 && edge_n != s - 1; k++) wait_clks(1);
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
      end
    join
    wait_clks(32);
    check("fullpop_count", {{(32-CW){1'b0}}, rx_count}, exp_q.size());
    check("fullpop_ovr", ov_cnt, exp_ov);
    drain();
    check("fullpop_last", {24'd0, last_pop}, 32'h7E);

    // Reset during data bit 4 with three bytes queued
    send_ok(8'h11);
    send_ok(8'h22);
    send_ok(8'h33);
    check("rst_pre_count", {{(32-CW){1'b0}}, rx_count}, exp_q.size());
    fork
      send_frame(8'hF0, 1'b1, 1'b0);
      begin
        wait_clks(5 * BIT_CLKS + 64);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_mid_outputs", {16'd0, rx_valid, rx_count, rx_data, frame_err, overrun}, 32'd0);
        wait_clks(8);
        rst_n = 1'b1;
      end
    join
    wait_clks(2 * BIT_CLKS);
    check("rst_post_count", {{(32-CW){1'b0}}, rx_count}, exp_q.size());
    check("rst_post_valid", {31'd0, rx_valid}, 32'd0);
    send_ok(8'h0F);
    check("rst_next_count", {{(32-CW){1'b0}}, rx_count}, exp_q.size());
    check("rst_next_head", {24'd0, rx_data}, 32'h0F);
    drain();
    check("final_fe", fe_cnt, exp_fe);
    check("final_ovr", ov_cnt, exp_ov);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
